// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-style to sram_like bus converter.
// Holds the handshake FSM state encoding and the bus transfer-size codes.
package sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // A read always moves the whole data path.
    function automatic logic [1:0] full_size(input int data_w);
        return (data_w == 64) ? SIZE_D : SIZE_W;
    endfunction

endpackage

// File: rtl/sram_like_size_enc.sv
// Combinational byte-enable to bus transfer size encoder.
// Unsupported enable patterns fall back to a full-width transfer and raise err_wen.
module sram_like_size_enc
    import sram_like_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] wen,
    output logic [1:0]          size,
    output logic                err_wen
);

    localparam int NB = DATA_W / 8;

    // Only naturally aligned runs of 1, 2, 4 or 8 bytes are legal.
    always_comb begin
        size    = full_size(DATA_W);
        err_wen = 1'b0;
        if (wen != '0) begin
            err_wen = 1'b1;
            for (int i = 0; i < NB; i++) begin
                if (wen == NB'(32'd1 << i)) begin
                    size    = SIZE_B;
                    err_wen = 1'b0;
                end
            end
            for (int i = 0; i < NB; i += 2) begin
                if (wen == NB'(32'd3 << i)) begin
                    size    = SIZE_H;
                    err_wen = 1'b0;
                end
            end
            for (int i = 0; i < NB; i += 4) begin
                if (wen == NB'(32'd15 << i)) begin
                    size    = SIZE_W;
                    err_wen = 1'b0;
                end
            end
            if (NB == 8 && wen == '1) begin
                size    = SIZE_D;
                err_wen = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_like_conv.sv
// Converts a single-cycle sram-style CPU port into a split address/data sram_like bus
// transaction, stalling the CPU until the data phase completes.
module sram_like_conv
    import sram_like_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int HOLD_RDATA = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    input  logic                longest_stall,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata
);

    state_t              state, state_next;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rbuf;
    logic                err_wen;
    logic                cpu_wr;
    logic                launch;
    logic [1:0]          enc_size;
    logic                enc_err;

    assign cpu_wr = |cpu_wen;
    assign launch = (state == IDLE) && cpu_en;

    sram_like_size_enc #(.DATA_W(DATA_W)) u_size_enc (
        .wen     (cpu_wen),
        .size    (enc_size),
        .err_wen (enc_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
            err_wen <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                wr_q    <= cpu_wr;
                size_q  <= enc_size;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                if (cpu_wr && enc_err) begin
                    err_wen <= 1'b1;
                end
            end
            if (state == WAIT && data_ok) begin
                rbuf <= rdata;
            end
        end
    end

    // In the launch cycle the bus sees the CPU fields directly; afterwards the latched copy.
    always_comb begin
        state_next = state;
        req        = launch || (state == REQ);
        wr         = launch ? cpu_wr    : wr_q;
        size       = launch ? enc_size  : size_q;
        addr       = launch ? cpu_addr  : addr_q;
        wdata      = launch ? cpu_wdata : wdata_q;
        cpu_stall  = cpu_en && (state != DONE);
        case (state)
            IDLE: if (cpu_en) state_next = addr_ok ? WAIT : REQ;
            REQ:  if (addr_ok) state_next = WAIT;
            WAIT: if (data_ok) state_next = DONE;
            DONE: if (!longest_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state == WAIT && data_ok && HOLD_RDATA == 0) begin
            cpu_stall = 1'b0;
        end
        if (rst) begin
            cpu_stall = 1'b0;
        end
    end

    assign cpu_rdata = (HOLD_RDATA != 0) ? rbuf : rdata;

    // The enable-pattern error is sticky until reset.
    assert property (@(posedge clk) disable iff (rst) err_wen |=> err_wen);

endmodule

// File: tb/tb_sram_like_conv.sv
// Randomized self-checking bench: a 32-bit held-data port and a 64-bit pass-through port
// driven as a bus slave, compared against a transaction-level model of the converter.
module tb_sram_like_conv;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_cpu_en, a_cpu_stall, a_longest_stall, a_req, a_wr, a_addr_ok, a_data_ok;
    logic [3:0]  a_cpu_wen;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata, a_addr, a_wdata, a_rdata;
    logic [1:0]  a_size;

    logic        b_cpu_en, b_cpu_stall, b_longest_stall, b_req, b_wr, b_addr_ok, b_data_ok;
    logic [7:0]  b_cpu_wen;
    logic [31:0] b_cpu_addr, b_addr;
    logic [63:0] b_cpu_wdata, b_cpu_rdata, b_wdata, b_rdata;
    logic [1:0]  b_size;

    int checks = 0;
    int errors = 0;
    logic exp_err_a = 1'b0;
    logic exp_err_b = 1'b0;

    always #5 clk = ~clk;

    sram_like_conv #(.ADDR_W(32), .DATA_W(32), .HOLD_RDATA(1)) dut_a (
        .clk(clk), .rst(rst), .cpu_en(a_cpu_en), .cpu_wen(a_cpu_wen), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
        .longest_stall(a_longest_stall), .req(a_req), .wr(a_wr), .size(a_size), .addr(a_addr),
        .wdata(a_wdata), .addr_ok(a_addr_ok), .data_ok(a_data_ok), .rdata(a_rdata)
    );

    sram_like_conv #(.ADDR_W(32), .DATA_W(64), .HOLD_RDATA(0)) dut_b (
        .clk(clk), .rst(rst), .cpu_en(b_cpu_en), .cpu_wen(b_cpu_wen), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .longest_stall(b_longest_stall), .req(b_req), .wr(b_wr), .size(b_size), .addr(b_addr),
        .wdata(b_wdata), .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata)
    );

    // Reference size rule: count enabled bytes and demand a naturally aligned contiguous run.
    function automatic logic [1:0] model_size(input int nbytes, input logic [7:0] wen, output bit bad);
        int n;
        int lo;
        logic [7:0] mask;
        logic [1:0] full;
        full = (nbytes == 8) ? 2'd3 : 2'd2;
        n = 0;
        lo = 0;
        bad = 1'b0;
        for (int i = nbytes - 1; i >= 0; i--) begin
            if (wen[i]) begin
                n++;
                lo = i;
            end
        end
        if (n == 0) return full;
        mask = 8'(((1 << n) - 1) << lo);
        bad = (wen != mask) || !(n == 1 || n == 2 || n == 4 || n == 8) || (lo % n != 0);
        if (bad) return full;
        return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : (n == 4) ? 2'd2 : 2'd3;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn_a(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rd, input logic [31:0] stray_rd,
                             input int da, input int dd, input int hold, input bit drop_en);
        bit bad;
        logic [1:0] es;
        logic [67:0] exp_f;
        es = model_size(4, {4'b0, wen}, bad);
        exp_f = {1'b1, |wen, es, addr, wdata};
        if ((|wen) && bad) exp_err_a = 1'b1;
        a_cpu_en = 1'b1; a_cpu_wen = wen; a_cpu_addr = addr; a_cpu_wdata = wdata;
        a_longest_stall = 1'b1; a_data_ok = 1'b0;
        for (int c = 0; c <= da; c++) begin
            if (c > 0) begin
                a_cpu_wen = 4'($urandom); a_cpu_addr = $urandom; a_cpu_wdata = $urandom;
                if (drop_en) a_cpu_en = 1'($urandom_range(0, 1));
            end
            a_addr_ok = (c == da);
            @(negedge clk);
            checks++;
            if ({a_req, a_wr, a_size, a_addr, a_wdata} !== exp_f) begin
                errors++;
                $display("[TB] FAIL a_req_fields cycle %0d: got %h expected %h", c,
                         {a_req, a_wr, a_size, a_addr, a_wdata}, exp_f);
            end
            checks++;
            if (a_cpu_stall !== a_cpu_en) begin
                errors++;
                $display("[TB] FAIL a_stall_req cycle %0d: got %b expected %b", c, a_cpu_stall, a_cpu_en);
            end
            next_cycle();
        end
        a_addr_ok = 1'b0;
        for (int c = 1; c <= dd; c++) begin
            a_data_ok = (c == dd);
            a_rdata = (c == dd) ? rd : $urandom;
            if (drop_en) a_cpu_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({a_req, a_cpu_stall} !== {1'b0, a_cpu_en}) begin
                errors++;
                $display("[TB] FAIL a_wait cycle %0d: got req/stall %b expected %b", c,
                         {a_req, a_cpu_stall}, {1'b0, a_cpu_en});
            end
            next_cycle();
        end
        for (int s = 0; s <= hold; s++) begin
            a_longest_stall = (s < hold);
            a_cpu_en = (s < hold);
            a_rdata = stray_rd;
            a_data_ok = 1'($urandom_range(0, 1));
            a_addr_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({a_req, a_cpu_stall} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL a_done_handshake: got req/stall %b expected 00", {a_req, a_cpu_stall});
            end
            checks++;
            if (a_cpu_rdata !== rd) begin
                errors++;
                $display("[TB] FAIL a_done_rdata: got %h expected %h", a_cpu_rdata, rd);
            end
            next_cycle();
        end
        a_cpu_en = 1'b0; a_data_ok = 1'b1; a_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_req, a_cpu_stall, a_cpu_rdata} !== {2'b00, rd}) begin
            errors++;
            $display("[TB] FAIL a_idle_after: got %h expected %h", {a_req, a_cpu_stall, a_cpu_rdata}, {2'b00, rd});
        end
        next_cycle();
        a_data_ok = 1'b0; a_addr_ok = 1'b0;
        checks++;
        if (dut_a.err_wen !== exp_err_a) begin
            errors++;
            $display("[TB] FAIL a_err_wen: got %b expected %b", dut_a.err_wen, exp_err_a);
        end
    endtask

    task automatic run_txn_b(input logic [7:0] wen, input logic [31:0] addr, input logic [63:0] wdata,
                             input logic [63:0] rd, input int dd);
        bit bad;
        logic [1:0] es;
        logic [99:0] exp_f;
        es = model_size(8, wen, bad);
        exp_f = {1'b1, |wen, es, addr, wdata};
        if ((|wen) && bad) exp_err_b = 1'b1;
        b_cpu_en = 1'b1; b_cpu_wen = wen; b_cpu_addr = addr; b_cpu_wdata = wdata;
        b_addr_ok = 1'b1; b_data_ok = 1'b0; b_longest_stall = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_req, b_wr, b_size, b_addr, b_wdata, b_cpu_stall} !== {exp_f, 1'b1}) begin
            errors++;
            $display("[TB] FAIL b_launch: got %h expected %h", {b_req, b_wr, b_size, b_addr, b_wdata, b_cpu_stall},
                     {exp_f, 1'b1});
        end
        next_cycle();
        b_addr_ok = 1'b0;
        for (int c = 1; c <= dd; c++) begin
            b_data_ok = (c == dd);
            b_rdata = (c == dd) ? rd : {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (b_cpu_stall !== (c != dd)) begin
                errors++;
                $display("[TB] FAIL b_wait_stall cycle %0d: got %b expected %b", c, b_cpu_stall, c != dd);
            end
            if (c == dd) begin
                checks++;
                if (b_cpu_rdata !== rd) begin
                    errors++;
                    $display("[TB] FAIL b_passthru_rdata: got %h expected %h", b_cpu_rdata, rd);
                end
            end
            next_cycle();
        end
        b_data_ok = 1'b0; b_cpu_en = 1'b0; b_longest_stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_req, b_cpu_stall} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b_done: got req/stall %b expected 00", {b_req, b_cpu_stall});
        end
        next_cycle();
        checks++;
        if (dut_b.err_wen !== exp_err_b) begin
            errors++;
            $display("[TB] FAIL b_err_wen: got %b expected %b", dut_b.err_wen, exp_err_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_cpu_en = 1'b0; a_cpu_wen = '0; a_cpu_addr = '0; a_cpu_wdata = '0; a_longest_stall = 1'b0;
        a_addr_ok = 1'b0; a_data_ok = 1'b0; a_rdata = '0;
        b_cpu_en = 1'b0; b_cpu_wen = '0; b_cpu_addr = '0; b_cpu_wdata = '0; b_longest_stall = 1'b0;
        b_addr_ok = 1'b0; b_data_ok = 1'b0; b_rdata = '0;
        repeat (2) next_cycle();
        a_cpu_en = 1'b1; b_cpu_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_cpu_stall, b_cpu_stall} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %b expected 00", {a_cpu_stall, b_cpu_stall});
        end
        next_cycle();
        a_cpu_en = 1'b0; b_cpu_en = 1'b0; rst = 1'b0;
        exp_err_a = 1'b0; exp_err_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_req, a_wr, a_size, a_addr, a_wdata, a_cpu_rdata} !== 100'h0) begin
            errors++;
            $display("[TB] FAIL reset_a_outputs: got %h expected 0", {a_req, a_wr, a_size, a_addr, a_wdata, a_cpu_rdata});
        end
        checks++;
        if ({b_req, b_wr, b_size, b_addr, b_wdata, dut_a.err_wen, dut_b.err_wen} !== 102'h0) begin
            errors++;
            $display("[TB] FAIL reset_b_outputs: got %h expected 0",
                     {b_req, b_wr, b_size, b_addr, b_wdata, dut_a.err_wen, dut_b.err_wen});
        end
        next_cycle();
    endtask

    task automatic test_read_zero_wait();
        run_txn_a(4'b0000, 32'h1FC00000, $urandom, 32'hDEADBEEF, $urandom, 0, 1, 0, 1'b0);
    endtask

    task automatic test_byte_write_delay();
        run_txn_a(4'b0100, 32'h80000002, 32'h00AB0000, $urandom, $urandom, 3, int'($urandom_range(1, 3)), 0, 1'b0);
    endtask

    task automatic test_held_read();
        run_txn_a(4'b0000, $urandom, $urandom, 32'hCAFEF00D, 32'h12345678, 1, 2, 5, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        a_cpu_en = 1'b1; a_cpu_wen = 4'b0000; a_cpu_addr = $urandom; a_addr_ok = 1'b1; a_longest_stall = 1'b1;
        next_cycle();
        a_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_cpu_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wait_stall: got %b expected 0", a_cpu_stall);
        end
        next_cycle();
        rst = 1'b0; a_cpu_en = 1'b0; a_data_ok = 1'b1; a_rdata = $urandom;
        exp_err_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_req, a_cpu_stall, a_cpu_rdata} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL rst_wait_after: got %h expected 0", {a_req, a_cpu_stall, a_cpu_rdata});
        end
        next_cycle();
        a_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_cpu_rdata, dut_a.err_wen} !== 33'h0) begin
            errors++;
            $display("[TB] FAIL rst_stray_data_ok: got %h expected 0", {a_cpu_rdata, dut_a.err_wen});
        end
        next_cycle();
        run_txn_a(4'b0000, $urandom, $urandom, $urandom, $urandom, 0, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            logic [3:0] wen;
            wen = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom);
            run_txn_a(wen, $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_wide_halfword();
        run_txn_b(8'h30, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1);
        run_txn_b(8'h05, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 2);
    endtask

    task automatic test_passthru_read();
        run_txn_b(8'h00, $urandom, {$urandom, $urandom}, 64'h0000_0000_0BAD_CAFE, 2);
        run_txn_b(8'hFF, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1);
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_byte_write_delay();
        test_held_read();
        test_reset_in_wait();
        test_random();
        test_wide_halfword();
        test_passthru_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
